// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-port signals around mem_arbiter.
// Latency: none, wires only.
// Backpressure: none here; req_cs_i is held until req_ack_o, and mem_cs_o is held until mem_ack_i.
//
// Ports (signals):
//   req_cs_i/req_we_i   per-channel request and write enable
//   req_addr_i/req_data_i  packed per-channel address and write data (channel k at k*W +: W)
//   req_data_o/req_ack_o/req_err_o  shared read data, one-hot completion pulse, abort flag
//   mem_*               single backing-memory port with cs/we/ack handshake
//   grant_o/busy_o      debug view of the current grant and activity
// Modports: slave = arbiter view, master = requesters plus memory (environment) view.
interface mem_arbiter_if #(
    parameter int N_CH       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [N_CH-1:0]            req_cs_i;
    logic [N_CH-1:0]            req_we_i;
    logic [N_CH*ADDR_WIDTH-1:0] req_addr_i;
    logic [N_CH*DATA_WIDTH-1:0] req_data_i;
    logic [DATA_WIDTH-1:0]      req_data_o;
    logic [N_CH-1:0]            req_ack_o;
    logic                       req_err_o;
    logic                       mem_cs_o;
    logic                       mem_we_o;
    logic [ADDR_WIDTH-1:0]      mem_addr_o;
    logic [DATA_WIDTH-1:0]      mem_data_o;
    logic [DATA_WIDTH-1:0]      mem_data_i;
    logic                       mem_ack_i;
    logic [2:0]                 grant_o;
    logic                       busy_o;

    modport slave (
        input  req_cs_i, req_we_i, req_addr_i, req_data_i, mem_data_i, mem_ack_i,
        output req_data_o, req_ack_o, req_err_o, mem_cs_o, mem_we_o, mem_addr_o,
               mem_data_o, grant_o, busy_o
    );

    modport master (
        output req_cs_i, req_we_i, req_addr_i, req_data_i, mem_data_i, mem_ack_i,
        input  req_data_o, req_ack_o, req_err_o, mem_cs_o, mem_we_o, mem_addr_o,
               mem_data_o, grant_o, busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting N_CH memory requesters onto one cs/we/ack memory port.
// Latency: request sampled at t -> mem_cs_o from t+1 -> req_ack_o one cycle after mem_ack_i; 3-cycle minimum turnaround.
// Backpressure: requesters hold req_cs_i until their one-cycle req_ack_o; the memory stalls by withholding mem_ack_i.
//
// Ports: clk, rst (synchronous, active high) plus mem_arbiter_if.slave bus
//   (per-channel req_cs/we/addr/data in, shared req_data_o, one-hot req_ack_o, req_err_o,
//    mem_cs/we/addr/data out, mem_data_i/mem_ack_i in, grant_o/busy_o debug).
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT
//   cycles without mem_ack_i (ack with req_err_o = 1 and req_data_o = 0).
module mem_arbiter #(
    parameter int N_CH       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    if (N_CH < 1 || N_CH > 8 || TIMEOUT < 2 || ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_param
        $error("mem_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    localparam logic [N_CH-1:0] ACK_ONE = N_CH'(1);

    state_t                state;
    logic [2:0]            last_grant;
    logic [2:0]            grant_q;
    cmd_t                  cmd_q;
    logic                  cs_q;
    logic                  busy_q;
    logic [N_CH-1:0]       ack_q;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Round-robin pick: first requesting channel after last_grant, wrapping modulo N_CH.
    logic [7:0] cs_pad;
    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_vld;
    cmd_t       pick_cmd;

    always_comb begin
        cs_pad   = 8'(bus.req_cs_i);
        cand     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = 3'((int'(last_grant) + i) % N_CH);
            if (!pick_vld && cs_pad[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        pick_cmd = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (pick_idx == 3'(k)) begin
                pick_cmd.we   = bus.req_we_i[k];
                pick_cmd.addr = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                pick_cmd.data = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 3'(N_CH - 1);
            grant_q    <= '0;
            cmd_q      <= '0;
            cs_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            rdata_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= '0;
                    if (pick_vld) begin
                        // Command is captured here; later changes on req_* are ignored.
                        grant_q <= pick_idx;
                        cmd_q   <= pick_cmd;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack coinciding with the timeout cycle wins: normal completion.
                    if (bus.mem_ack_i) begin
                        rdata_q    <= bus.mem_data_i;
                        last_grant <= grant_q;
                        ack_q      <= ACK_ONE << grant_q;
                        cs_q       <= 1'b0;
                        state      <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Advance the pointer on abort too, so a dead target cannot pin one channel.
                        rdata_q    <= '0;
                        last_grant <= grant_q;
                        ack_q      <= ACK_ONE << grant_q;
                        err_q      <= 1'b1;
                        cs_q       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    ack_q  <= '0;
                    busy_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs_o   = cs_q;
    assign bus.mem_we_o   = cmd_q.we;
    assign bus.mem_addr_o = cmd_q.addr;
    assign bus.mem_data_o = cmd_q.data;
    assign bus.req_ack_o  = ack_q;
    assign bus.req_data_o = rdata_q;
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.req_err_o  = err_q;
`else
    assign bus.req_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-channel and a 4-channel instance on one clock.
// Latency: not applicable.
// Backpressure: the bench plays requesters and memory, acking after chosen delays or never.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic tie_a;
    logic ack_a;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.N_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ia ();
    mem_arbiter_if #(.N_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ib ();

    mem_arbiter #(.N_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.slave)
    );

    mem_arbiter #(.N_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.slave)
    );

    // tie_a models a zero-latency memory that acks whenever it is selected.
    assign ia.mem_ack_i = tie_a ? ia.mem_cs_o : ack_a;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         cs_cnt;
        int         wait_n;
        logic       ack_seen;
        logic       exp_g;
        logic [8:0] ack_pat;
        logic [8:0] cs_pat;

        rst_a = 1'b1;
        rst_b = 1'b1;
        tie_a = 1'b0;
        ack_a = 1'b0;
        ia.req_cs_i = '0; ia.req_we_i = '0; ia.req_addr_i = '0; ia.req_data_i = '0;
        ia.mem_data_i = '0;
        ib.req_cs_i = '0; ib.req_we_i = '0; ib.req_addr_i = '0; ib.req_data_i = '0;
        ib.mem_data_i = '0; ib.mem_ack_i = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cs_a",    64'(ia.mem_cs_o),   64'(0));
        check("rst_busy_a",  64'(ia.busy_o),     64'(0));
        check("rst_grant_a", 64'(ia.grant_o),    64'(0));
        check("rst_ack_a",   64'(ia.req_ack_o),  64'(0));
        check("rst_data_a",  64'(ia.req_data_o), 64'(0));
        check("rst_err_a",   64'(ia.req_err_o),  64'(0));
        check("rst_addr_a",  64'(ia.mem_addr_o), 64'(0));
        check("rst_cs_b",    64'(ib.mem_cs_o),   64'(0));
        check("rst_ack_b",   64'(ib.req_ack_o),  64'(0));
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Test 1: ch0 read of 0x10, memory acks 8 cycles after cs
        ia.req_addr_i[31:0] = 32'h10;
        ia.req_cs_i = 2'b01;
        tick();
        check("t1_grant", 64'(ia.grant_o),    64'(0));
        check("t1_busy",  64'(ia.busy_o),     64'(1));
        check("t1_addr",  64'(ia.mem_addr_o), 64'(32'h10));
        check("t1_we",    64'(ia.mem_we_o),   64'(0));
        cs_cnt = 0;
        ack_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ia.mem_cs_o) cs_cnt++;
            if (ia.req_ack_o != 2'b00) ack_seen = 1'b1;
            tick();
        end
        ack_a = 1'b1;
        ia.mem_data_i = 32'hDEADBEEF;
        if (ia.mem_cs_o) cs_cnt++;
        tick();
        ack_a = 1'b0;
        ia.req_cs_i = 2'b00;
        check("t1_cs_cycles", 64'(cs_cnt),        64'(9));
        check("t1_early_ack", 64'(ack_seen),      64'(0));
        check("t1_ack",       64'(ia.req_ack_o),  64'(2'b01));
        check("t1_rdata",     64'(ia.req_data_o), 64'(32'hDEADBEEF));
        check("t1_cs_done",   64'(ia.mem_cs_o),   64'(0));
        check("t1_err",       64'(ia.req_err_o),  64'(0));
        tick();
        check("t1_ack_clr",   64'(ia.req_ack_o),  64'(0));
        check("t1_busy_clr",  64'(ia.busy_o),     64'(0));
        check("t1_rdata_hold", 64'(ia.req_data_o), 64'(32'hDEADBEEF));

        // Test 2: both channels continuously; grants alternate from ch0
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        ia.req_addr_i = {32'h20, 32'h40};
        ia.req_data_i = {32'h12345678, 32'h0};
        ia.req_we_i = 2'b10;
        ia.req_cs_i = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            exp_g = n[0];
            check("t2_grant", 64'(ia.grant_o),  64'(exp_g));
            check("t2_cs",    64'(ia.mem_cs_o), 64'(1));
            check("t2_we",    64'(ia.mem_we_o), 64'(exp_g));
            check("t2_addr",  64'(ia.mem_addr_o), exp_g ? 64'(32'h20) : 64'(32'h40));
            check("t2_wdata", 64'(ia.mem_data_o), exp_g ? 64'(32'h12345678) : 64'(0));
            ack_a = 1'b1;
            ia.mem_data_i = 32'(32'hA0 + n);
            tick();
            ack_a = 1'b0;
            check("t2_ack",   64'(ia.req_ack_o),  exp_g ? 64'(2'b10) : 64'(2'b01));
            check("t2_rdata", 64'(ia.req_data_o), 64'(32'hA0 + n));
            if (n == 3) ia.req_cs_i = 2'b00;
            tick();
        end
        check("t2_idle_ack", 64'(ia.req_ack_o), 64'(0));

        // Test 4: zero-latency memory, single channel back to back
        tie_a = 1'b1;
        ia.req_cs_i = 2'b01;
        ack_pat = '0;
        cs_pat = '0;
        for (int k = 0; k < 9; k++) begin
            tick();
            ack_pat[k] = ia.req_ack_o[0];
            cs_pat[k] = ia.mem_cs_o;
            if (k == 7) ia.req_cs_i = 2'b00;
        end
        check("t4_ack_pattern", 64'(ack_pat), 64'(9'b010010010));
        check("t4_cs_pattern",  64'(cs_pat),  64'(9'b001001001));
        tie_a = 1'b0;
        tick();

        // Test 5: reset mid-BUSY aborts silently and restores ch0 priority
        ia.req_cs_i = 2'b10;
        tick();
        check("t5_grant_pre", 64'(ia.grant_o), 64'(1));
        tick();
        rst_a = 1'b1;
        tick();
        check("t5_cs",    64'(ia.mem_cs_o),   64'(0));
        check("t5_busy",  64'(ia.busy_o),     64'(0));
        check("t5_grant", 64'(ia.grant_o),    64'(0));
        check("t5_ack",   64'(ia.req_ack_o),  64'(0));
        check("t5_rdata", 64'(ia.req_data_o), 64'(0));
        check("t5_addr",  64'(ia.mem_addr_o), 64'(0));
        check("t5_we",    64'(ia.mem_we_o),   64'(0));
        check("t5_wdata", 64'(ia.mem_data_o), 64'(0));
        rst_a = 1'b0;
        ia.req_cs_i = 2'b11;
        tick();
        check("t5_grant_post", 64'(ia.grant_o),   64'(0));
        check("t5_no_ack",     64'(ia.req_ack_o), 64'(0));
        ack_a = 1'b1;
        ia.mem_data_i = 32'h55;
        tick();
        ack_a = 1'b0;
        ia.req_cs_i = 2'b00;
        check("t5_ack_post", 64'(ia.req_ack_o),  64'(2'b01));
        check("t5_rdata2",   64'(ia.req_data_o), 64'(32'h55));
        tick();

        // Test 3: N_CH=4, ch2 first, then ch1+ch3 -> ch3 then ch1
        ib.req_addr_i = {32'h203, 32'h202, 32'h201, 32'h200};
        ib.req_cs_i = 4'b0100;
        tick();
        check("t3_grant_2", 64'(ib.grant_o),    64'(2));
        check("t3_addr_2",  64'(ib.mem_addr_o), 64'(32'h202));
        ib.mem_ack_i = 1'b1;
        ib.mem_data_i = 32'h12;
        tick();
        ib.mem_ack_i = 1'b0;
        check("t3_ack_2", 64'(ib.req_ack_o), 64'(4'b0100));
        ib.req_cs_i = 4'b1010;
        tick();
        tick();
        check("t3_grant_3", 64'(ib.grant_o),    64'(3));
        check("t3_addr_3",  64'(ib.mem_addr_o), 64'(32'h203));
        ib.mem_ack_i = 1'b1;
        ib.mem_data_i = 32'h13;
        tick();
        ib.mem_ack_i = 1'b0;
        check("t3_ack_3", 64'(ib.req_ack_o), 64'(4'b1000));
        ib.req_cs_i = 4'b0010;
        tick();
        tick();
        check("t3_grant_1", 64'(ib.grant_o), 64'(1));
        ib.mem_ack_i = 1'b1;
        ib.mem_data_i = 32'h11;
        tick();
        ib.mem_ack_i = 1'b0;
        check("t3_ack_1",   64'(ib.req_ack_o),  64'(4'b0010));
        check("t3_rdata_1", 64'(ib.req_data_o), 64'(32'h11));
        ib.req_cs_i = 4'b0000;
        tick();

        // Stray memory ack in IDLE is ignored
        ib.mem_ack_i = 1'b1;
        ib.mem_data_i = 32'h77;
        tick();
        check("stray_ack",   64'(ib.req_ack_o),  64'(0));
        check("stray_busy",  64'(ib.busy_o),     64'(0));
        check("stray_rdata", 64'(ib.req_data_o), 64'(32'h11));
        ib.mem_ack_i = 1'b0;
        tick();
        check("stray_ack2",  64'(ib.req_ack_o),  64'(0));

        // Requester drops cs and changes address after grant; command stays latched
        ib.req_addr_i[31:0] = 32'h300;
        ib.req_cs_i = 4'b0001;
        tick();
        check("drop_grant", 64'(ib.grant_o),    64'(0));
        ib.req_cs_i = 4'b0000;
        ib.req_addr_i[31:0] = 32'h999;
        tick();
        check("drop_addr", 64'(ib.mem_addr_o), 64'(32'h300));
        check("drop_cs",   64'(ib.mem_cs_o),   64'(1));
        ib.mem_ack_i = 1'b1;
        tick();
        ib.mem_ack_i = 1'b0;
        check("drop_ack",  64'(ib.req_ack_o),  64'(4'b0001));
        tick();

        // Test 6: memory never acks
`ifdef MEM_ARB_TIMEOUT_EN
        ia.req_cs_i = 2'b01;
        ia.mem_data_i = 32'h99;
        tick();
        cs_cnt = 0;
        wait_n = 0;
        while (ia.req_ack_o == 2'b00 && wait_n < 40) begin
            if (ia.mem_cs_o) cs_cnt++;
            tick();
            wait_n++;
        end
        ia.req_cs_i = 2'b00;
        check("t6_ack",       64'(ia.req_ack_o),  64'(2'b01));
        check("t6_cs_cycles", 64'(cs_cnt),        64'(16));
        check("t6_err",       64'(ia.req_err_o),  64'(1));
        check("t6_rdata",     64'(ia.req_data_o), 64'(0));
        check("t6_cs",        64'(ia.mem_cs_o),   64'(0));
        tick();
        check("t6_err_clr",   64'(ia.req_err_o),  64'(0));
        ack_a = 1'b1;
        tick();
        check("t6_late_ack",  64'(ia.req_ack_o),  64'(0));
        check("t6_late_busy", 64'(ia.busy_o),     64'(0));
        ack_a = 1'b0;
        tick();
        check("t6_late_ack2", 64'(ia.req_ack_o),  64'(0));
        check("t6_late_data", 64'(ia.req_data_o), 64'(0));
`else
        ia.req_cs_i = 2'b01;
        tick();
        cs_cnt = 0;
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ia.mem_cs_o) cs_cnt++;
            if (ia.req_ack_o != 2'b00) ack_seen = 1'b1;
            tick();
        end
        check("t6_wait_cs",  64'(cs_cnt),       64'(20));
        check("t6_wait_ack", 64'(ack_seen),     64'(0));
        check("t6_wait_err", 64'(ia.req_err_o), 64'(0));
        ack_a = 1'b1;
        ia.mem_data_i = 32'h66;
        tick();
        ack_a = 1'b0;
        ia.req_cs_i = 2'b00;
        check("t6_ack",   64'(ia.req_ack_o),  64'(2'b01));
        check("t6_err",   64'(ia.req_err_o),  64'(0));
        check("t6_rdata", 64'(ia.req_data_o), 64'(32'h66));
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
